// File: rtl/dfr_node_sequencer_if.sv
// Handshake bundle between the DFR node sequencer, its sample source, the ASIC
// function interface and the node-state consumer.
interface dfr_node_sequencer_if #(
    parameter int NUM_NODES = 16
);
    localparam int IDX_W = $clog2(NUM_NODES);

    logic [15:0]          sample_in;
    logic                 sample_valid;
    logic                 sample_ready;
    logic [NUM_NODES-1:0] mask;
    logic [15:0]          asic_data_in;
    logic                 asic_start;
    logic                 xadc_data_valid;
    logic [15:0]          xadc_data_out;
    logic [15:0]          node_out;
    logic                 node_out_valid;
    logic [IDX_W-1:0]     node_index;
    logic                 frame_done;
    logic                 timeout_err;

    // master: environment side (sample source, ASIC stub, node consumer)
    modport master (
        output sample_in, sample_valid, mask, xadc_data_valid, xadc_data_out,
        input  sample_ready, asic_data_in, asic_start, node_out, node_out_valid,
               node_index, frame_done, timeout_err
    );

    // slave: the sequencer itself
    modport slave (
        input  sample_in, sample_valid, mask, xadc_data_valid, xadc_data_out,
        output sample_ready, asic_data_in, asic_start, node_out, node_out_valid,
               node_index, frame_done, timeout_err
    );
endinterface

// File: rtl/dfr_node_sequencer.sv
// Delayed-feedback reservoir node sequencer: walks NUM_NODES virtual nodes per sample.
// Optional macro DFR_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on each conversion.
module dfr_node_sequencer #(
    parameter int NUM_NODES      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                 clk,
    input logic                 rst,
    dfr_node_sequencer_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int IDX_W  = $clog2(NUM_NODES);
    localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(NUM_NODES - 1);

    if (NUM_NODES < 2 || NUM_NODES > 256 || (NUM_NODES & (NUM_NODES - 1)) != 0) begin : g_bad_nodes
        $error("NUM_NODES must be a power of two in 2..256");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, STORE} state_t;

    state_t            state;
    logic [DATA_W-1:0] sample_q;
    logic [IDX_W-1:0]  node_k;
    logic [IDX_W-1:0]  node_nxt;
    logic [DATA_W-1:0] mem [NUM_NODES];
    logic              xv_q;
    logic              xv_rise;
    logic              wait_done;
    logic              timeout_hit;
    logic [DATA_W-1:0] result;

    // Half-scale input plus half-scale feedback; two halves of 16-bit words never overflow.
    function automatic logic [DATA_W-1:0] drive_word(input logic [DATA_W-1:0] s,
                                                     input logic              m,
                                                     input logic [DATA_W-1:0] fb);
        logic [DATA_W-1:0] masked;
        masked = m ? s : '0;
        return (masked >> 1) + (fb >> 1);
    endfunction

    assign node_nxt = node_k + IDX_W'(1);
    assign xv_rise  = bus.xadc_data_valid && !xv_q;

`ifdef DFR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT) && !xv_rise && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt        <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.timeout_err <= timeout_hit;
            if (state != WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + TO_W'(1);
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // A timed-out conversion is reported as a zero result.
    always_comb begin
        wait_done = (state == WAIT) && (xv_rise || timeout_hit);
        result    = xv_rise ? bus.xadc_data_out : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            sample_q           <= '0;
            node_k             <= '0;
            xv_q               <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++)
                mem[i] <= '0;
            bus.sample_ready   <= 1'b1;
            bus.asic_data_in   <= '0;
            bus.asic_start     <= 1'b0;
            bus.node_out       <= '0;
            bus.node_out_valid <= 1'b0;
            bus.node_index     <= '0;
            bus.frame_done     <= 1'b0;
        end else begin
            xv_q               <= bus.xadc_data_valid;
            bus.asic_start     <= 1'b0;
            bus.node_out_valid <= 1'b0;
            bus.frame_done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        sample_q         <= bus.sample_in;
                        node_k           <= '0;
                        bus.asic_data_in <= drive_word(bus.sample_in, bus.mask[0], mem[0]);
                        bus.asic_start   <= 1'b1;
                        bus.sample_ready <= 1'b0;
                        state            <= LOAD;
                    end
                end

                LOAD: state <= WAIT;

                // Node outputs are registered here so they appear one cycle after the edge.
                WAIT: begin
                    if (wait_done) begin
                        bus.node_out       <= result;
                        bus.node_index     <= node_k;
                        bus.node_out_valid <= 1'b1;
                        bus.frame_done     <= (node_k == LAST_NODE);
                        state              <= STORE;
                    end
                end

                STORE: begin
                    mem[node_k] <= bus.node_out;
                    if (node_k == LAST_NODE) begin
                        bus.sample_ready <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        node_k           <= node_nxt;
                        bus.asic_data_in <= drive_word(sample_q, bus.mask[node_nxt], mem[node_nxt]);
                        bus.asic_start   <= 1'b1;
                        state            <= LOAD;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dfr_node_sequencer.sv
// Randomized self-checking bench for dfr_node_sequencer with NUM_NODES = 4.
// Build with or without DFR_TIMEOUT_EN; the silent-stub frame checks whichever behaviour applies.
module tb_dfr_node_sequencer;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfr_node_sequencer_if #(.NUM_NODES(N)) bus ();

    dfr_node_sequencer #(.NUM_NODES(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] mem_m [N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        foreach (mem_m[i]) mem_m[i] = 16'h0000;
    endtask

    // mode 0: stub answers after a random delay; 1: valid held high across LOAD first;
    // 2: stub silent. abort_node >= 0 pulses rst during that node's WAIT.
    task automatic do_frame(input logic [15:0] s, input logic [N-1:0] m, input int mode,
                            input bit use_fix, input logic [15:0] fixval, input int abort_node);
        logic [15:0] val;
        int exp_word;
        int seen;
        @(negedge clk);
        check("ready_idle", bus.sample_ready, 1);
        bus.sample_in    = s;
        bus.mask         = m;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        for (int n = 0; n < N; n++) begin
            exp_word = (m[n] ? int'(s) : 0) / 2 + int'(mem_m[n]) / 2;
            check($sformatf("start_n%0d", n), bus.asic_start, 1);
            check($sformatf("drive_n%0d", n), bus.asic_data_in, exp_word);
            check("ready_busy", bus.sample_ready, 0);
            // samples offered while busy must be ignored
            bus.sample_valid = 1'($urandom);
            bus.sample_in    = 16'($urandom);

            if (abort_node == n) begin
                bus.xadc_data_valid = 1'b0;
                bus.sample_valid    = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check("rst_ready", bus.sample_ready, 1);
                check("rst_start", bus.asic_start, 0);
                check("rst_out", bus.node_out, 0);
                check("rst_drive", bus.asic_data_in, 0);
                @(negedge clk);
                rst = 1'b0;
                bus.xadc_data_valid = 1'b1;
                bus.xadc_data_out   = 16'hBEEF;
                seen = 0;
                repeat (4) begin
                    @(negedge clk);
                    seen += int'(bus.asic_start) + int'(bus.node_out_valid);
                    bus.xadc_data_valid = 1'b0;
                end
                check("abort_quiet", seen, 0);
                check("abort_ready", bus.sample_ready, 1);
                clear_model();
                return;
            end

            if (mode == 2) begin
                bus.xadc_data_valid = 1'b0;
                seen = 0;
`ifdef DFR_TIMEOUT_EN
                repeat (TO) begin
                    @(negedge clk);
                    seen += int'(bus.node_out_valid);
                end
                check("to_early", seen, 0);
                bus.sample_valid = 1'b0;
                @(negedge clk);
                check("to_err", bus.timeout_err, 1);
                check("to_valid", bus.node_out_valid, 1);
                check("to_out", bus.node_out, 0);
                mem_m[n] = 16'h0000;
`else
                repeat (3 * TO) begin
                    @(negedge clk);
                    seen += int'(bus.node_out_valid) + int'(bus.timeout_err);
                end
                check("hang_quiet", seen, 0);
                check("hang_ready", bus.sample_ready, 0);
                bus.sample_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("hang_rst_ready", bus.sample_ready, 1);
                clear_model();
                return;
`endif
            end else begin
                if (mode == 1) begin
                    bus.xadc_data_valid = 1'b1;
                    bus.xadc_data_out   = 16'hDEAD;
                    seen = 0;
                    repeat (3) begin
                        @(negedge clk);
                        seen += int'(bus.node_out_valid);
                    end
                    check("hold_nocap", seen, 0);
                    bus.xadc_data_valid = 1'b0;
                end
                @(negedge clk);
                check("start_once", bus.asic_start, 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                val = use_fix ? fixval : 16'($urandom);
                bus.xadc_data_valid = 1'b1;
                bus.xadc_data_out   = val;
                @(negedge clk);
                bus.xadc_data_valid = 1'b0;
                bus.xadc_data_out   = 16'($urandom);
                bus.sample_valid    = 1'b0;
                check("out_valid", bus.node_out_valid, 1);
                check("out_data", bus.node_out, val);
                check("no_timeout", bus.timeout_err, 0);
                mem_m[n] = val;
            end
            check("out_index", bus.node_index, n);
            check("frame_done", bus.frame_done, n == N - 1);
            @(negedge clk);
        end
        check("ready_end", bus.sample_ready, 1);
        check("valid_end", bus.node_out_valid, 0);
    endtask

    initial begin
        bus.sample_in       = '0;
        bus.sample_valid    = 1'b0;
        bus.mask            = '0;
        bus.xadc_data_valid = 1'b0;
        bus.xadc_data_out   = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_ready0", bus.sample_ready, 1);
        check("rst_start0", bus.asic_start, 0);
        check("rst_drive0", bus.asic_data_in, 0);
        check("rst_out0", bus.node_out, 0);
        check("rst_valid0", bus.node_out_valid, 0);
        check("rst_index0", bus.node_index, 0);
        check("rst_done0", bus.frame_done, 0);
        check("rst_to0", bus.timeout_err, 0);
        rst = 1'b0;

        do_frame(16'h8000, 4'b0101, 0, 1'b1, 16'h1234, -1);
        do_frame(16'h8000, 4'b0101, 0, 1'b1, 16'h1234, -1);
        do_frame(16'h8000, 4'b0101, 1, 1'b1, 16'h1234, -1);
        repeat (6) do_frame(16'($urandom), N'($urandom), int'($urandom_range(0, 1)), 1'b0, 16'h0000, -1);
        do_frame(16'($urandom), 4'b1111, 0, 1'b0, 16'h0000, 2);
        do_frame(16'hFFFF, 4'b1111, 0, 1'b1, 16'h5555, -1);
        do_frame(16'hFFFF, 4'b1010, 2, 1'b0, 16'h0000, -1);
        do_frame(16'($urandom), N'($urandom), 0, 1'b0, 16'h0000, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
